instr_fetch: RTL and testbench

Instruction fetch stage of the 8-bit CPU core. It sits directly downstream of `program_rom` and drives the ROM byte address. It reads one byte per cycle and assembles variable-length instructions (opcode plus 0–2 operand bytes). It then presents each complete instruction to the decoder over a valid/ready handshake and accepts PC redirects from execute.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode constants, fetch state encoding and the
//               instruction length lookup used by fetch and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADD_IMM = 8'h01;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // Unknown opcodes are treated as single-byte so the stream never stalls.
    function automatic logic [1:0] instr_len(input logic [7:0] opcode);
        logic [1:0] len;
        case (opcode)
            OP_LDA_IMM, OP_ADD_IMM: len = 2'd2;
            OP_JMP_ABS:             len = 2'd3;
            default:                len = 2'd1;
        endcase
        return len;
    endfunction

    function automatic logic opcode_legal(input logic [7:0] opcode);
        return (opcode == OP_LDA_IMM) || (opcode == OP_ADD_IMM) || (opcode == OP_JMP_ABS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Byte-serial instruction fetch; assembles 1-3 byte
//               instructions from program_rom and hands them to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [15:0] instr_operand,
    output logic [15:0] instr_pc,
    output logic        instr_illegal,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic         r_valid;
    logic [7:0]   r_opcode;
    logic [15:0]  r_operand;
    logic [15:0]  r_instr_pc;
    logic         r_illegal;

    logic [1:0]   w_len_new;
    logic [1:0]   w_len_cur;
    logic [15:0]  w_pc_inc;

    assign w_len_new = instr_len(rom_data);
    assign w_len_cur = instr_len(r_opcode);
    assign w_pc_inc  = r_pc + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_OP;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_opcode   <= 8'h00;
            r_operand  <= 16'h0000;
            r_instr_pc <= 16'h0000;
            r_illegal  <= 1'b0;
        end else if (redirect_valid) begin
            // A transfer in this same cycle has already been consumed downstream.
            r_state <= S_OP;
            r_pc    <= redirect_addr;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_OP: begin
                    r_opcode   <= rom_data;
                    r_operand  <= 16'h0000;
                    r_instr_pc <= r_pc;
                    r_illegal  <= ~opcode_legal(rom_data);
                    r_pc       <= w_pc_inc;
                    if (w_len_new == 2'd1) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    r_operand <= {8'h00, rom_data};
                    r_pc      <= w_pc_inc;
                    if (w_len_cur == 2'd3) begin
                        r_state <= S_HI;
                    end else begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end
                end
                S_HI: begin
                    r_operand[15:8] <= rom_data;
                    r_pc            <= w_pc_inc;
                    r_state         <= S_HOLD;
                    r_valid         <= 1'b1;
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        r_state <= S_OP;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_OP;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr      = r_pc;
    assign instr_valid   = r_valid;
    assign instr_opcode  = r_opcode;
    assign instr_operand = r_operand;
    assign instr_pc      = r_instr_pc;
    assign instr_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed vector table,
//               reset/wrap sequences and a random run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        instr_valid;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
    logic        instr_illegal;

    logic        ready2;
    logic [15:0] rom_addr2;
    logic [7:0]  rom_data2;
    logic        valid2;
    logic [7:0]  opcode2;
    logic [15:0] operand2;
    logic [15:0] pc2;
    logic        illegal2;

    logic [7:0] rom  [0:65535];
    logic [7:0] rom2 [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom2[rom_addr2];

    instr_fetch #(.RESET_PC(16'h0000)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .instr_illegal (instr_illegal),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr)
    );

    instr_fetch #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr2),
        .rom_data      (rom_data2),
        .instr_valid   (valid2),
        .instr_ready   (ready2),
        .instr_opcode  (opcode2),
        .instr_operand (operand2),
        .instr_pc      (pc2),
        .instr_illegal (illegal2),
        .redirect_valid(1'b0),
        .redirect_addr (16'h0000)
    );

    typedef struct {
        logic        ready;
        logic        redir;
        logic [15:0] raddr;
        logic        e_valid;
        logic [7:0]  e_op;
        logic [15:0] e_opd;
        logic [15:0] e_pc;
        logic [15:0] e_ra;
    } vec_t;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opd;
        logic        ill;
        int          len;
    } ins_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [15:0] ra,
                                input logic ev, input logic [7:0] eop, input logic [15:0] eopd,
                                input logic [15:0] epc, input logic [15:0] era);
        vec_t v;
        v.ready = rdy; v.redir = rd; v.raddr = ra;
        v.e_valid = ev; v.e_op = eop; v.e_opd = eopd; v.e_pc = epc; v.e_ra = era;
        return v;
    endfunction

    // Reference decode straight from the opcode table, reading the ROM image.
    function automatic ins_t decode(input logic [15:0] a);
        ins_t r;
        logic [15:0] a1, a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        r.op = rom[a];
        case (r.op)
            8'hA9, 8'h01: begin r.len = 2; r.ill = 1'b0; r.opd = {8'h00, rom[a1]}; end
            8'h4C:        begin r.len = 3; r.ill = 1'b0; r.opd = {rom[a2], rom[a1]}; end
            default:      begin r.len = 1; r.ill = 1'b1; r.opd = 16'h0000; end
        endcase
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic av, input logic [7:0] aop, input logic [15:0] aopd,
                       input logic [15:0] apc, input logic aill, input logic [15:0] ara,
                       input logic ev, input logic [7:0] eop, input logic [15:0] eopd,
                       input logic [15:0] epc, input logic eill, input logic [15:0] era,
                       input logic full);
        logic ok;
        ok = (av === ev) && (ara === era);
        if (full)
            ok = ok && (aop === eop) && (aopd === eopd) && (apc === epc) && (aill === eill);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b op=%h opd=%h pc=%h ill=%0b ra=%h, want valid=%0b op=%h opd=%h pc=%h ill=%0b ra=%h",
                     name, av, aop, aopd, apc, aill, ara, ev, eop, eopd, epc, eill, era);
        end
    endtask

    task automatic chk1(input string name, input logic ev, input logic [7:0] eop,
                        input logic [15:0] eopd, input logic [15:0] epc, input logic eill,
                        input logic [15:0] era, input logic full);
        chk(name, instr_valid, instr_opcode, instr_operand, instr_pc, instr_illegal, rom_addr,
            ev, eop, eopd, epc, eill, era, full);
    endtask

    task automatic chk2(input string name, input logic ev, input logic [7:0] eop,
                        input logic [15:0] eopd, input logic [15:0] epc, input logic eill,
                        input logic [15:0] era, input logic full);
        chk(name, valid2, opcode2, operand2, pc2, illegal2, rom_addr2,
            ev, eop, eopd, epc, eill, era, full);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        m_valid;
    logic [15:0] m_start;
    logic [15:0] m_next;
    int          m_left;
    ins_t        m_ins;
    ins_t        m_cur;
    logic [15:0] m_ra;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            rom[i]  = 8'h00;
            rom2[i] = 8'h00;
        end
        rom[0] = 8'hA9; rom[1] = 8'h00; rom[2] = 8'h01; rom[3] = 8'h01;
        rom[4] = 8'h4C; rom[5] = 8'h02; rom[6] = 8'h00;
        rom2[16'hFFFE] = 8'hFF; rom2[16'hFFFF] = 8'h4C;
        rom2[0] = 8'h34; rom2[1] = 8'h12; rom2[2] = 8'hA9; rom2[3] = 8'h55;

        rst = 1'b1; instr_ready = 1'b0; ready2 = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 16'h0000;
        step();
        chk1("reset", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        rst = 1'b0;

        // Cycle-by-cycle power-on, backpressure and redirect vectors.
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0001));
        vq.push_back(mk(0, 0, 16'h0, 1, 8'hA9, 16'h0000, 16'h0000, 16'h0002));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 0, 16'h0, 1, 8'hA9, 16'h0000, 16'h0000, 16'h0002));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0002));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0003));
        vq.push_back(mk(1, 0, 16'h0, 1, 8'h01, 16'h0001, 16'h0002, 16'h0004));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0004));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0005));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0006));
        vq.push_back(mk(0, 0, 16'h0, 1, 8'h4C, 16'h0002, 16'h0004, 16'h0007));
        vq.push_back(mk(0, 0, 16'h0, 1, 8'h4C, 16'h0002, 16'h0004, 16'h0007));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0007));
        vq.push_back(mk(1, 1, 16'h2, 0, 8'h00, 16'h0000, 16'h0000, 16'h0002));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0003));
        vq.push_back(mk(1, 0, 16'h0, 1, 8'h01, 16'h0001, 16'h0002, 16'h0004));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0004));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0005));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0006));
        vq.push_back(mk(1, 1, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0001));
        vq.push_back(mk(1, 0, 16'h0, 1, 8'hA9, 16'h0000, 16'h0000, 16'h0002));
        vq.push_back(mk(1, 1, 16'h4, 0, 8'h00, 16'h0000, 16'h0000, 16'h0004));
        vq.push_back(mk(1, 0, 16'h0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0005));

        foreach (vq[i]) begin
            instr_ready    = vq[i].ready;
            redirect_valid = vq[i].redir;
            redirect_addr  = vq[i].raddr;
            step();
            chk1($sformatf("vec%0d", i), vq[i].e_valid, vq[i].e_op, vq[i].e_opd,
                 vq[i].e_pc, 1'b0, vq[i].e_ra, vq[i].e_valid);
        end
        redirect_valid = 1'b0;

        // Reset while in the operand-low state, then while holding a valid instruction.
        rst = 1'b1;
        step();
        chk1("rst_in_lo", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        rst = 1'b0; instr_ready = 1'b0;
        step();
        step();
        chk1("resume1", 1'b1, 8'hA9, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b1);
        step();
        chk1("hold_stall", 1'b1, 8'hA9, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b1);
        rst = 1'b1;
        step();
        chk1("rst_in_hold", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        rst = 1'b0; instr_ready = 1'b1;
        step();
        step();
        chk1("resume2", 1'b1, 8'hA9, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b1);

        // Illegal opcode and PC wrap on the FFFE-reset instance.
        rst = 1'b1;
        step();
        chk2("wrap_reset", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'hFFFE, 1'b1);
        rst = 1'b0; ready2 = 1'b0;
        step();
        chk2("illegal", 1'b1, 8'hFF, 16'h0000, 16'hFFFE, 1'b1, 16'hFFFF, 1'b1);
        ready2 = 1'b1;
        step();
        chk2("illegal_xfer", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        ready2 = 1'b0;
        step();
        chk2("wrap_lo", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        step();
        chk2("wrap_hi", 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0);
        step();
        chk2("wrap_jmp", 1'b1, 8'h4C, 16'h1234, 16'hFFFF, 1'b0, 16'h0002, 1'b1);

        // Random program, random backpressure and redirects against the model.
        for (int i = 0; i < 65536; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rom[i] = (r < 4) ? 8'hA9 : (r < 6) ? 8'h01 : (r < 8) ? 8'h4C : 8'($urandom);
        end
        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
        step();
        rst = 1'b0;
        m_valid = 1'b0;
        m_start = 16'h0000;
        m_next  = 16'h0000;
        m_cur   = decode(m_start);
        m_ins   = m_cur;
        m_left  = m_cur.len;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 4))
                                                         : 16'($urandom);
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_start = redirect_addr;
                m_cur   = decode(m_start);
                m_left  = m_cur.len;
            end else if (m_valid) begin
                if (instr_ready) begin
                    m_valid = 1'b0;
                    m_start = m_next;
                    m_cur   = decode(m_start);
                    m_left  = m_cur.len;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_ins   = m_cur;
                    m_next  = m_start + 16'(m_cur.len);
                end
            end
            m_ra = m_valid ? m_next : m_start + 16'(m_cur.len - m_left);
            step();
            chk1($sformatf("rand%0d", cyc), m_valid, m_ins.op, m_ins.opd, m_start,
                 m_ins.ill, m_ra, m_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
